matmul_multi_engine_ctrl: RTL and testbench
===========================================

Name: matmul_multi_engine_ctrl

Overview:
- APB-slave control/status block that sequences NUM_ENGINES independent matmul engines.
- Each engine has its own A/B/C base addresses, validity masks, strides, a start/done handshake, a run-cycle counter and an interrupt source.
- Successor to the single-engine register/start-done logic in the matmul top level: it sits between the host APB bus and a bank of matmul_8x8_systolic-style engines.

Parameters:
- NUM_ENGINES, 2, number of engines (1..7)
- AWIDTH, 11, BRAM address width
- MASK_WIDTH, 8, validity-mask width per dimension
- ADDR_STRIDE_WIDTH, 8, stride field width
- MAT_MUL_SIZE, 8, reset value of every stride
- REG_ADDRWIDTH, 8, PADDR width
- REG_DATAWIDTH, 32, PWDATA/PRDATA width

Ports:
- clk  in  1  single clock; APB and engine side are synchronous to it
- resetn  in  1  asynchronous active-low reset
- PADDR  in  REG_ADDRWIDTH  byte address
- PSEL, PENABLE, PWRITE  in  1 each  APB controls
- PWDATA  in  REG_DATAWIDTH  write data
- PRDATA  out  REG_DATAWIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- start_mat_mul  out  NUM_ENGINES  per-engine start level
- done_mat_mul  in  NUM_ENGINES  per-engine done level
- address_mat_a/b/c  out  NUM_ENGINES*AWIDTH  flattened base addresses; engine e at [e*AWIDTH +: AWIDTH]
- validity_mask_a_rows, validity_mask_a_cols_b_rows, validity_mask_b_cols  out  NUM_ENGINES*MASK_WIDTH  flattened
- address_stride_a/b/c  out  NUM_ENGINES*ADDR_STRIDE_WIDTH  flattened
- irq  out  1  level interrupt

Behaviour:
- Reset (async assert, sync deassert use): PRDATA=0, PREADY=0, PSLVERR=0, start_mat_mul=0, irq=0, all addresses=0, masks all ones, strides=MAT_MUL_SIZE, IRQ_EN=0, done=0, cycle counters=0, every engine FSM IDLE, APB FSM IDLE.
- APB FSM states are IDLE, ACCESS, RESP.
  - IDLE: PSEL&!PENABLE -> ACCESS.
  - ACCESS: PSEL&PENABLE -> RESP; the write commits or the read samples at this edge.
  - RESP: PREADY=1 for exactly one cycle, with PRDATA/PSLVERR valid, then -> IDLE.
  - Every transfer therefore has exactly one wait state. PRDATA returns to 0 in IDLE.
- Register map, byte addresses:
  - 0x00 CTRL
    - Write bit e=1 starts engine e (self-clearing).
    - Write bit 16+e=1 clears done[e] (W1C).
    - Read returns busy[e] at bit e and done[e] at bit 16+e.
  - 0x04 IRQ_EN, bits [NUM_ENGINES-1:0].
  - Engine e block at base 0x20+0x20*e:
    - +0x00 A address
    - +0x04 B address
    - +0x08 C address
    - +0x0C masks {b_cols[23:16], a_cols_b_rows[15:8], a_rows[7:0]}
    - +0x10 strides {c[23:16], b[15:8], a[7:0]}
    - +0x14 cycle count (RO, 32-bit)
  - Unused register bits read 0.
- PSLVERR=1 (the write has no effect) in these cases:
  - any access to an unmapped address;
  - a write to a config register of an engine whose busy=1;
  - a write to a read-only register.
- Engine FSM, per engine: IDLE -> ARM -> RUN -> DONE.
  - IDLE: a CTRL start bit moves the engine to ARM.
  - ARM: start_mat_mul[e]<=1; clear the cycle counter; -> RUN.
  - RUN: counter increments every cycle and saturates at 0xFFFFFFFF. When done_mat_mul[e]=1: start_mat_mul[e]<=0, done[e]<=1, -> DONE.
  - DONE: counter holds. The engine returns to IDLE when done[e] is cleared through CTRL.
  - busy[e]=1 in ARM and RUN.
- Start requested while not IDLE: ignored for that engine and PSLVERR=1; other engines in the same write still start.
- Clear-done and start for the same engine in one write: clear takes effect, the engine goes to IDLE, and the start is ignored without error.
- Simultaneous starts of several engines are allowed; each engine is independent.
- irq is registered: irq = |(done & IRQ_EN), updated one cycle after a change in done or IRQ_EN.
- done_mat_mul is level-sensitive and sampled only in RUN.
- Asserting resetn mid-run drops start_mat_mul immediately (asynchronously) and returns all state to reset values.

Test Plan:
1. Reset, then read 0x2C (engine 0 masks), 0x30 (engine 0 strides) and 0x00 -> PRDATA 0x00FFFFFF, 0x00080808, 0x00000000; PREADY pulses once per read, two cycles after PSEL.
2. Write 0x20=0x123 and 0x40=0x456; read both back -> 0x123 and 0x456; address_mat_a = {0x456,0x123}; PSLVERR=0.
3. Write CTRL=0x3; drive done_mat_mul[0] high 10 cycles after start rises.
   - start_mat_mul=2'b11 one cycle after the write commits; start_mat_mul[0] falls when done is sampled.
   - CTRL read shows 0x00010002; cycle count at 0x34 equals 10 (±1 per edge convention, fixed by bench).
4. IRQ_EN=0x1, engine 0 completes -> irq=1 one cycle after done[0] sets. Write CTRL=0x00010000 -> irq=0 next cycle; CTRL bit16=0.
5. Error cases, each -> PSLVERR=1 and state unchanged:
   - write 0x20 while engine 0 is busy;
   - write CTRL=0x1 while engine 0 is busy;
   - read 0xF0 (unmapped).
6. Drop resetn during RUN with start_mat_mul=2'b01 -> start_mat_mul=0 immediately, before the next clk edge; all registers read their reset values afterwards.

Source files
------------

// File: rtl/matmul_multi_engine_ctrl.sv
// APB control/status block that sequences a bank of independent matmul engines.
// Each engine has its own base addresses, masks, strides, start/done handshake,
// a saturating run-cycle counter and a contribution to the shared interrupt.
module matmul_multi_engine_ctrl #(
  parameter int NUM_ENGINES       = 2,
  parameter int AWIDTH            = 11,
  parameter int MASK_WIDTH        = 8,
  parameter int ADDR_STRIDE_WIDTH = 8,
  parameter int MAT_MUL_SIZE      = 8,
  parameter int REG_ADDRWIDTH     = 8,
  parameter int REG_DATAWIDTH     = 32
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [REG_ADDRWIDTH-1:0]               PADDR,
  input  logic                                   PSEL,
  input  logic                                   PENABLE,
  input  logic                                   PWRITE,
  input  logic [REG_DATAWIDTH-1:0]               PWDATA,
  output logic [REG_DATAWIDTH-1:0]               PRDATA,
  output logic                                   PREADY,
  output logic                                   PSLVERR,
  output logic [NUM_ENGINES-1:0]                 start_mat_mul,
  input  logic [NUM_ENGINES-1:0]                 done_mat_mul,
  output logic [NUM_ENGINES*AWIDTH-1:0]          address_mat_a,
  output logic [NUM_ENGINES*AWIDTH-1:0]          address_mat_b,
  output logic [NUM_ENGINES*AWIDTH-1:0]          address_mat_c,
  output logic [NUM_ENGINES*MASK_WIDTH-1:0]      validity_mask_a_rows,
  output logic [NUM_ENGINES*MASK_WIDTH-1:0]      validity_mask_a_cols_b_rows,
  output logic [NUM_ENGINES*MASK_WIDTH-1:0]      validity_mask_b_cols,
  output logic [NUM_ENGINES*ADDR_STRIDE_WIDTH-1:0] address_stride_a,
  output logic [NUM_ENGINES*ADDR_STRIDE_WIDTH-1:0] address_stride_b,
  output logic [NUM_ENGINES*ADDR_STRIDE_WIDTH-1:0] address_stride_c,
  output logic                                   irq
);

  typedef enum logic [1:0] {APB_IDLE, APB_ACCESS, APB_RESP} apb_state_t;
  typedef enum logic [1:0] {ENG_IDLE, ENG_ARM, ENG_RUN, ENG_DONE} eng_state_t;

  apb_state_t               apb_state;
  eng_state_t               eng_state [NUM_ENGINES];
  logic [31:0]              cycle_count [NUM_ENGINES];
  logic [NUM_ENGINES-1:0]   done_flags;
  logic [NUM_ENGINES-1:0]   irq_en;
  logic [NUM_ENGINES-1:0]   busy;

  logic [REG_DATAWIDTH-1:0] rd_data;
  logic                     acc_err;
  logic [NUM_ENGINES-1:0]   start_req;
  logic [NUM_ENGINES-1:0]   clear_req;
  logic [NUM_ENGINES-1:0]   eng_sel;
  logic [2:0]               blk;
  logic [4:0]               off;
  logic                     addr_ok;
  logic                     commit;
  logic                     wr_commit;
  logic                     unused_pwdata;

  // Upper write-data bits have no register behind them.
  assign unused_pwdata = ^PWDATA;

  assign commit    = (apb_state == APB_ACCESS) && PSEL && PENABLE;
  assign wr_commit = commit && PWRITE;

  // An engine counts as busy from the moment it is armed until done is seen.
  always_comb begin
    busy = '0;
    for (int e = 0; e < NUM_ENGINES; e++)
      busy[e] = (eng_state[e] == ENG_ARM) || (eng_state[e] == ENG_RUN);
  end

  // Address decode: read mux, error detection and per-engine request vectors.
  always_comb begin
    rd_data   = '0;
    acc_err   = 1'b0;
    start_req = '0;
    clear_req = '0;
    eng_sel   = '0;
    blk       = PADDR[7:5];
    off       = PADDR[4:0];
    addr_ok   = ((PADDR >> 8) == '0) && (PADDR[1:0] == 2'b00);
    if (!addr_ok) begin
      acc_err = 1'b1;
    end else if (blk == 3'd0) begin
      case (off)
        5'h00: begin
          rd_data[NUM_ENGINES-1:0]  = busy;
          rd_data[16 +: NUM_ENGINES] = done_flags;
          if (PWRITE) begin
            clear_req = PWDATA[16 +: NUM_ENGINES];
            for (int e = 0; e < NUM_ENGINES; e++) begin
              if (PWDATA[e] && !PWDATA[16+e]) begin
                if (eng_state[e] == ENG_IDLE) start_req[e] = 1'b1;
                else                          acc_err      = 1'b1;
              end
            end
          end
        end
        5'h04:   rd_data[NUM_ENGINES-1:0] = irq_en;
        default: acc_err = 1'b1;
      endcase
    end else begin
      acc_err = 1'b1;
      for (int e = 0; e < NUM_ENGINES; e++) begin
        if (blk == 3'(e + 1)) begin
          acc_err    = 1'b0;
          eng_sel[e] = 1'b1;
          case (off)
            5'h00: rd_data[AWIDTH-1:0] = address_mat_a[e*AWIDTH +: AWIDTH];
            5'h04: rd_data[AWIDTH-1:0] = address_mat_b[e*AWIDTH +: AWIDTH];
            5'h08: rd_data[AWIDTH-1:0] = address_mat_c[e*AWIDTH +: AWIDTH];
            5'h0C: begin
              rd_data[0  +: MASK_WIDTH] = validity_mask_a_rows[e*MASK_WIDTH +: MASK_WIDTH];
              rd_data[8  +: MASK_WIDTH] = validity_mask_a_cols_b_rows[e*MASK_WIDTH +: MASK_WIDTH];
              rd_data[16 +: MASK_WIDTH] = validity_mask_b_cols[e*MASK_WIDTH +: MASK_WIDTH];
            end
            5'h10: begin
              rd_data[0  +: ADDR_STRIDE_WIDTH] = address_stride_a[e*ADDR_STRIDE_WIDTH +: ADDR_STRIDE_WIDTH];
              rd_data[8  +: ADDR_STRIDE_WIDTH] = address_stride_b[e*ADDR_STRIDE_WIDTH +: ADDR_STRIDE_WIDTH];
              rd_data[16 +: ADDR_STRIDE_WIDTH] = address_stride_c[e*ADDR_STRIDE_WIDTH +: ADDR_STRIDE_WIDTH];
            end
            5'h14: begin
              rd_data = REG_DATAWIDTH'(cycle_count[e]);
              if (PWRITE) acc_err = 1'b1;
            end
            default: acc_err = 1'b1;
          endcase
          if (PWRITE && busy[e] && (off <= 5'h10)) acc_err = 1'b1;
        end
      end
    end
  end

  // APB slave FSM: one wait state, response registered for exactly one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      apb_state <= APB_IDLE;
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      PSLVERR   <= 1'b0;
    end else begin
      case (apb_state)
        APB_IDLE: begin
          PREADY  <= 1'b0;
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
          if (PSEL && !PENABLE) apb_state <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (PSEL && PENABLE) begin
            apb_state <= APB_RESP;
            PREADY    <= 1'b1;
            PRDATA    <= PWRITE ? '0 : rd_data;
            PSLVERR   <= acc_err;
          end else if (!PSEL) begin
            apb_state <= APB_IDLE;
          end
        end
        APB_RESP: begin
          apb_state <= APB_IDLE;
          PREADY    <= 1'b0;
          PRDATA    <= '0;
          PSLVERR   <= 1'b0;
        end
        default: apb_state <= APB_IDLE;
      endcase
    end
  end

  // Configuration registers; a rejected write leaves everything untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en                      <= '0;
      address_mat_a               <= '0;
      address_mat_b               <= '0;
      address_mat_c               <= '0;
      validity_mask_a_rows        <= '1;
      validity_mask_a_cols_b_rows <= '1;
      validity_mask_b_cols        <= '1;
      address_stride_a            <= {NUM_ENGINES{ADDR_STRIDE_WIDTH'(MAT_MUL_SIZE)}};
      address_stride_b            <= {NUM_ENGINES{ADDR_STRIDE_WIDTH'(MAT_MUL_SIZE)}};
      address_stride_c            <= {NUM_ENGINES{ADDR_STRIDE_WIDTH'(MAT_MUL_SIZE)}};
    end else if (wr_commit && !acc_err) begin
      if ((blk == 3'd0) && (off == 5'h04)) irq_en <= PWDATA[NUM_ENGINES-1:0];
      for (int e = 0; e < NUM_ENGINES; e++) begin
        if (eng_sel[e]) begin
          case (off)
            5'h00: address_mat_a[e*AWIDTH +: AWIDTH] <= PWDATA[AWIDTH-1:0];
            5'h04: address_mat_b[e*AWIDTH +: AWIDTH] <= PWDATA[AWIDTH-1:0];
            5'h08: address_mat_c[e*AWIDTH +: AWIDTH] <= PWDATA[AWIDTH-1:0];
            5'h0C: begin
              validity_mask_a_rows[e*MASK_WIDTH +: MASK_WIDTH]        <= PWDATA[0  +: MASK_WIDTH];
              validity_mask_a_cols_b_rows[e*MASK_WIDTH +: MASK_WIDTH] <= PWDATA[8  +: MASK_WIDTH];
              validity_mask_b_cols[e*MASK_WIDTH +: MASK_WIDTH]        <= PWDATA[16 +: MASK_WIDTH];
            end
            5'h10: begin
              address_stride_a[e*ADDR_STRIDE_WIDTH +: ADDR_STRIDE_WIDTH] <= PWDATA[0  +: ADDR_STRIDE_WIDTH];
              address_stride_b[e*ADDR_STRIDE_WIDTH +: ADDR_STRIDE_WIDTH] <= PWDATA[8  +: ADDR_STRIDE_WIDTH];
              address_stride_c[e*ADDR_STRIDE_WIDTH +: ADDR_STRIDE_WIDTH] <= PWDATA[16 +: ADDR_STRIDE_WIDTH];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Per-engine sequencer: arm, run with a saturating counter, hold until cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_mat_mul <= '0;
      done_flags    <= '0;
      for (int e = 0; e < NUM_ENGINES; e++) begin
        eng_state[e]   <= ENG_IDLE;
        cycle_count[e] <= '0;
      end
    end else begin
      for (int e = 0; e < NUM_ENGINES; e++) begin
        case (eng_state[e])
          ENG_IDLE: if (wr_commit && start_req[e]) eng_state[e] <= ENG_ARM;
          ENG_ARM: begin
            start_mat_mul[e] <= 1'b1;
            cycle_count[e]   <= '0;
            eng_state[e]     <= ENG_RUN;
          end
          ENG_RUN: begin
            if (cycle_count[e] != 32'hFFFF_FFFF) cycle_count[e] <= cycle_count[e] + 32'd1;
            if (done_mat_mul[e]) begin
              start_mat_mul[e] <= 1'b0;
              done_flags[e]    <= 1'b1;
              eng_state[e]     <= ENG_DONE;
            end
          end
          ENG_DONE: begin
            if (wr_commit && clear_req[e]) begin
              done_flags[e] <= 1'b0;
              eng_state[e]  <= ENG_IDLE;
            end
          end
          default: eng_state[e] <= ENG_IDLE;
        endcase
      end
    end
  end

  // Interrupt is a registered OR of enabled done flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= |(done_flags & irq_en);
  end

endmodule

// File: tb/tb_matmul_multi_engine_ctrl.sv
// Testbench for matmul_multi_engine_ctrl: directed APB traffic against a
// register-level model, with per-cycle output comparison and literal anchors.
module tb_matmul_multi_engine_ctrl;

  localparam int NE = 2;
  localparam int AW = 11;
  localparam int MW = 8;
  localparam int SW = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [7:0]        PADDR;
  logic              PSEL, PENABLE, PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [NE-1:0]     start_mat_mul;
  logic [NE-1:0]     done_mat_mul;
  logic [NE*AW-1:0]  address_mat_a, address_mat_b, address_mat_c;
  logic [NE*MW-1:0]  validity_mask_a_rows, validity_mask_a_cols_b_rows, validity_mask_b_cols;
  logic [NE*SW-1:0]  address_stride_a, address_stride_b, address_stride_c;
  logic              irq;

  matmul_multi_engine_ctrl #(
    .NUM_ENGINES(NE), .AWIDTH(AW), .MASK_WIDTH(MW), .ADDR_STRIDE_WIDTH(SW),
    .MAT_MUL_SIZE(8), .REG_ADDRWIDTH(8), .REG_DATAWIDTH(32)
  ) dut (
    .clk(clk), .resetn(resetn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
    .address_mat_a(address_mat_a), .address_mat_b(address_mat_b), .address_mat_c(address_mat_c),
    .validity_mask_a_rows(validity_mask_a_rows),
    .validity_mask_a_cols_b_rows(validity_mask_a_cols_b_rows),
    .validity_mask_b_cols(validity_mask_b_cols),
    .address_stride_a(address_stride_a), .address_stride_b(address_stride_b),
    .address_stride_c(address_stride_c), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Register-level model of the block as seen from the bus.
  logic [AW-1:0] m_addr_a [NE];
  logic [AW-1:0] m_addr_b [NE];
  logic [AW-1:0] m_addr_c [NE];
  logic [MW-1:0] m_mask_ar [NE];
  logic [MW-1:0] m_mask_acbr [NE];
  logic [MW-1:0] m_mask_bc [NE];
  logic [SW-1:0] m_str_a [NE];
  logic [SW-1:0] m_str_b [NE];
  logic [SW-1:0] m_str_c [NE];
  logic [31:0]   m_count [NE];
  logic [NE-1:0] m_irqen, m_busy, m_done;

  logic          exp_ready = 1'b0;
  logic [31:0]   exp_rdata = '0;
  logic          exp_err = 1'b0;

  logic [NE*AW-1:0] ea, eb, ec;
  logic [NE*MW-1:0] emar, emac, emb;
  logic [NE*SW-1:0] esa, esb, esc;

  logic [31:0] rd;
  logic        er;
  int          lat;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
  endtask

  task automatic modelReset();
    for (int e = 0; e < NE; e++) begin
      m_addr_a[e] = '0; m_addr_b[e] = '0; m_addr_c[e] = '0;
      m_mask_ar[e] = '1; m_mask_acbr[e] = '1; m_mask_bc[e] = '1;
      m_str_a[e] = SW'(8); m_str_b[e] = SW'(8); m_str_c[e] = SW'(8);
      m_count[e] = '0;
    end
    m_irqen = '0; m_busy = '0; m_done = '0;
    exp_ready = 1'b0; exp_rdata = '0; exp_err = 1'b0;
  endtask

  function automatic logic [31:0] modelRead(input logic [7:0] addr);
    logic [31:0] r;
    int e;
    r = '0;
    if (addr == 8'h00) begin
      r[NE-1:0] = m_busy;
      r[16 +: NE] = m_done;
    end else if (addr == 8'h04) begin
      r[NE-1:0] = m_irqen;
    end else if (addr >= 8'h20) begin
      e = (int'(addr) - 32) / 32;
      if (e < NE) begin
        case (addr[4:0])
          5'h00: r = 32'(m_addr_a[e]);
          5'h04: r = 32'(m_addr_b[e]);
          5'h08: r = 32'(m_addr_c[e]);
          5'h0C: r = {8'h00, m_mask_bc[e], m_mask_acbr[e], m_mask_ar[e]};
          5'h10: r = {8'h00, m_str_c[e], m_str_b[e], m_str_a[e]};
          5'h14: r = m_count[e];
          default: r = '0;
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic modelErr(input logic [7:0] addr, input logic wr, input logic [31:0] data);
    int e;
    if (addr[1:0] != 2'b00) return 1'b1;
    if (addr == 8'h00) begin
      if (!wr) return 1'b0;
      for (int k = 0; k < NE; k++)
        if (data[k] && !data[16+k] && (m_busy[k] || m_done[k])) return 1'b1;
      return 1'b0;
    end
    if (addr == 8'h04) return 1'b0;
    if (addr < 8'h20) return 1'b1;
    e = (int'(addr) - 32) / 32;
    if (e >= NE) return 1'b1;
    if (addr[4:0] > 5'h14) return 1'b1;
    if (addr[4:0] == 5'h14) return wr;
    return wr && m_busy[e];
  endfunction

  task automatic modelWrite(input logic [7:0] addr, input logic [31:0] data, input logic err);
    int e;
    if (addr == 8'h00) begin
      for (int k = 0; k < NE; k++) begin
        if (data[16+k]) m_done[k] = 1'b0;
        else if (data[k] && !m_busy[k] && !m_done[k]) m_busy[k] = 1'b1;
      end
    end else if (!err) begin
      if (addr == 8'h04) m_irqen = data[NE-1:0];
      else begin
        e = (int'(addr) - 32) / 32;
        case (addr[4:0])
          5'h00: m_addr_a[e] = data[AW-1:0];
          5'h04: m_addr_b[e] = data[AW-1:0];
          5'h08: m_addr_c[e] = data[AW-1:0];
          5'h0C: begin m_mask_ar[e] = data[7:0]; m_mask_acbr[e] = data[15:8]; m_mask_bc[e] = data[23:16]; end
          5'h10: begin m_str_a[e] = data[7:0]; m_str_b[e] = data[15:8]; m_str_c[e] = data[23:16]; end
          default: ;
        endcase
      end
    end
  endtask

  // One APB transfer; the model is updated at the commit edge.
  task automatic applyStimulus(input logic [7:0] addr, input logic wr, input logic [31:0] data,
                               output logic [31:0] rdata, output logic err);
    logic [31:0] e_rd;
    logic        e_err;
    e_err = modelErr(addr, wr, data);
    e_rd  = (wr || e_err) ? 32'h0 : modelRead(addr);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    exp_rdata = e_rd; exp_err = e_err; exp_ready = 1'b1;
    if (wr) modelWrite(addr, data, e_err);
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    exp_ready = 1'b0;
  endtask

  task automatic finishEngine(input int e, output int iters);
    done_mat_mul[e] = 1'b1;
    iters = 0;
    do begin
      @(posedge clk); #1;
      iters++;
    end while (start_mat_mul[e] && iters < 10);
    done_mat_mul[e] = 1'b0;
    m_busy[e] = 1'b0;
    m_done[e] = 1'b1;
  endtask

  // Called right after the start write: start rose at the previous edge.
  task automatic runEngine(input int e, input int n);
    int k;
    int it;
    k = 0;
    while (!start_mat_mul[e] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("start_rise", 32'(start_mat_mul[e]), 32'h1);
    repeat (n - 1) @(posedge clk);
    #1;
    finishEngine(e, it);
    checkOutput("done_latency", 32'(it), 32'h1);
    m_count[e] = 32'(n);
  endtask

  // Every cycle out of reset: configuration outputs and APB response versus the model.
  always @(negedge clk) begin
    if (resetn) begin
      for (int e = 0; e < NE; e++) begin
        ea[e*AW +: AW] = m_addr_a[e];
        eb[e*AW +: AW] = m_addr_b[e];
        ec[e*AW +: AW] = m_addr_c[e];
        emar[e*MW +: MW] = m_mask_ar[e];
        emac[e*MW +: MW] = m_mask_acbr[e];
        emb[e*MW +: MW]  = m_mask_bc[e];
        esa[e*SW +: SW] = m_str_a[e];
        esb[e*SW +: SW] = m_str_b[e];
        esc[e*SW +: SW] = m_str_c[e];
      end
      checkOutput("address_mat_a", 32'(address_mat_a), 32'(ea));
      checkOutput("address_mat_b", 32'(address_mat_b), 32'(eb));
      checkOutput("address_mat_c", 32'(address_mat_c), 32'(ec));
      checkOutput("mask_a_rows", 32'(validity_mask_a_rows), 32'(emar));
      checkOutput("mask_a_cols_b_rows", 32'(validity_mask_a_cols_b_rows), 32'(emac));
      checkOutput("mask_b_cols", 32'(validity_mask_b_cols), 32'(emb));
      checkOutput("stride_a", 32'(address_stride_a), 32'(esa));
      checkOutput("stride_b", 32'(address_stride_b), 32'(esb));
      checkOutput("stride_c", 32'(address_stride_c), 32'(esc));
      checkOutput("pready", 32'(PREADY), 32'(exp_ready));
      if (exp_ready) begin
        checkOutput("prdata", PRDATA, exp_rdata);
        checkOutput("pslverr", 32'(PSLVERR), 32'(exp_err));
      end else begin
        checkOutput("prdata_idle", PRDATA, 32'h0);
        checkOutput("pslverr_idle", 32'(PSLVERR), 32'h0);
      end
    end
  end

  // Directed sequence.
  initial begin
    resetn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; done_mat_mul = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_start", 32'(start_mat_mul), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_pready", 32'(PREADY), 32'h0);
    checkOutput("rst_stride_a", 32'(address_stride_a), 32'h0808);
    #2 resetn = 1'b1;

    // Reset readback
    applyStimulus(8'h2C, 1'b0, 32'h0, rd, er);
    checkOutput("t1_masks", rd, 32'h00FF_FFFF);
    applyStimulus(8'h30, 1'b0, 32'h0, rd, er);
    checkOutput("t1_strides", rd, 32'h0008_0808);
    applyStimulus(8'h00, 1'b0, 32'h0, rd, er);
    checkOutput("t1_ctrl", rd, 32'h0);

    // Address registers of both engines
    applyStimulus(8'h20, 1'b1, 32'h123, rd, er);
    checkOutput("t2_wr0_err", 32'(er), 32'h0);
    applyStimulus(8'h40, 1'b1, 32'h456, rd, er);
    checkOutput("t2_wr1_err", 32'(er), 32'h0);
    applyStimulus(8'h20, 1'b0, 32'h0, rd, er);
    checkOutput("t2_rd0", rd, 32'h123);
    applyStimulus(8'h40, 1'b0, 32'h0, rd, er);
    checkOutput("t2_rd1", rd, 32'h456);
    checkOutput("t2_addr_a", 32'(address_mat_a), 32'h0022_B123);
    applyStimulus(8'h4C, 1'b1, 32'h00A5_3C0F, rd, er);
    applyStimulus(8'h30, 1'b1, 32'h0004_0201, rd, er);

    // Both engines started together
    applyStimulus(8'h00, 1'b1, 32'h3, rd, er);
    checkOutput("t3_start_both", 32'(start_mat_mul), 32'h3);
    runEngine(0, 10);
    checkOutput("t3_start_after_done", 32'(start_mat_mul), 32'h2);
    applyStimulus(8'h00, 1'b0, 32'h0, rd, er);
    checkOutput("t3_ctrl", rd, 32'h0001_0002);
    applyStimulus(8'h34, 1'b0, 32'h0, rd, er);
    checkOutput("t3_count", rd, 32'd10);
    finishEngine(1, lat);
    checkOutput("t3_e1_latency", 32'(lat), 32'h1);
    applyStimulus(8'h00, 1'b1, 32'h0002_0002, rd, er);
    checkOutput("t3_clr_start_err", 32'(er), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t3_clr_start_nostart", 32'(start_mat_mul), 32'h0);
    applyStimulus(8'h00, 1'b0, 32'h0, rd, er);
    checkOutput("t3_ctrl2", rd, 32'h0001_0000);

    // Interrupt
    applyStimulus(8'h04, 1'b1, 32'h1, rd, er);
    checkOutput("t4_irq_en", 32'(irq), 32'h1);
    applyStimulus(8'h00, 1'b1, 32'h0001_0000, rd, er);
    checkOutput("t4_irq_clr", 32'(irq), 32'h0);
    applyStimulus(8'h00, 1'b1, 32'h1, rd, er);
    runEngine(0, 5);
    checkOutput("t4_irq_same", 32'(irq), 32'h0);
    @(posedge clk); #1;
    checkOutput("t4_irq_next", 32'(irq), 32'h1);
    applyStimulus(8'h00, 1'b1, 32'h0001_0000, rd, er);
    checkOutput("t4_irq_cleared", 32'(irq), 32'h0);
    applyStimulus(8'h00, 1'b0, 32'h0, rd, er);
    checkOutput("t4_ctrl", rd, 32'h0);
    applyStimulus(8'h34, 1'b0, 32'h0, rd, er);
    checkOutput("t4_count", rd, 32'd5);

    // Error cases
    applyStimulus(8'h00, 1'b1, 32'h1, rd, er);
    applyStimulus(8'h20, 1'b1, 32'h7FF, rd, er);
    checkOutput("t5_busy_wr_err", 32'(er), 32'h1);
    applyStimulus(8'h20, 1'b0, 32'h0, rd, er);
    checkOutput("t5_addr_kept", rd, 32'h123);
    applyStimulus(8'h00, 1'b1, 32'h1, rd, er);
    checkOutput("t5_restart_err", 32'(er), 32'h1);
    applyStimulus(8'hF0, 1'b0, 32'h0, rd, er);
    checkOutput("t5_unmapped_err", 32'(er), 32'h1);
    applyStimulus(8'h34, 1'b1, 32'h5, rd, er);
    checkOutput("t5_ro_err", 32'(er), 32'h1);
    applyStimulus(8'h40, 1'b1, 32'h055, rd, er);
    checkOutput("t5_idle_eng_wr", 32'(er), 32'h0);
    checkOutput("t5_start", 32'(start_mat_mul), 32'h1);

    // Reset during run
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6_start_async", 32'(start_mat_mul), 32'h0);
    modelReset();
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    applyStimulus(8'h20, 1'b0, 32'h0, rd, er);
    checkOutput("t6_addr", rd, 32'h0);
    applyStimulus(8'h2C, 1'b0, 32'h0, rd, er);
    checkOutput("t6_masks", rd, 32'h00FF_FFFF);
    applyStimulus(8'h30, 1'b0, 32'h0, rd, er);
    checkOutput("t6_strides", rd, 32'h0008_0808);
    applyStimulus(8'h34, 1'b0, 32'h0, rd, er);
    checkOutput("t6_count", rd, 32'h0);
    applyStimulus(8'h00, 1'b0, 32'h0, rd, er);
    checkOutput("t6_ctrl", rd, 32'h0);
    applyStimulus(8'h04, 1'b0, 32'h0, rd, er);
    checkOutput("t6_irq_en", rd, 32'h0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
